game_sequencer: RTL and testbench
=================================

# game_sequencer

Control FSM that sequences the board datapath from the player push-buttons. It turns raw key presses into the single-cycle strobes the datapath consumes, in the required order:
- `control_set`
- `right` / `down`
- `change_able_read` → `put` → `turn_control`

It also freezes play once the board check reports a winner, and sits between the board I/O keys and the datapath's control inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a key level is accepted.
- `DB_W`, default 20: debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.
- `clock` in 1: system clock.
- `resetn` in 1: reset; one clock; reset is synchronous and active-low.
- `key_put` in 1: put button, active-high pressed, asynchronous to `clock`.
- `key_right` in 1: move-right button, active-high, asynchronous.
- `key_down` in 1: move-down button, active-high, asynchronous.
- `game_status` in 2: board check result; 00 in play, 01 player0 won, 10/11 player1 won.
- `control_set` out 1: pointer re-home strobe.
- `right` out 1: pointer column-advance strobe.
- `down` out 1: pointer row-advance strobe.
- `change_able_read` out 1: window in which the datapath latches its write-enable.
- `put` out 1: board write strobe.
- `turn_control` out 1: player-change strobe.
- `busy` out 1: high in any state other than IDLE and OVER.
- `state` out 4: current state encoding, for debug/LEDs.

## Operation
- All outputs are registered. Every strobe is exactly one cycle high and at most one strobe is high per cycle.
- Keys pass through a 2-flop synchronizer, then the optional debouncer, giving clean levels `kp`, `kr`, `kd`.
- State transitions:
  - INIT: `control_set`=1 → IDLE.
  - IDLE:
    - `game_status`≠00 → OVER (this check has the highest priority).
    - else `kp` → CHOICE.
    - else `kr` → RIGHT.
    - else `kd` → DOWN.
    - else stay in IDLE.
  - CHOICE: `change_able_read`=1 → PUT.
  - PUT: `put`=1 → TURN.
  - TURN: `turn_control`=1 → WAIT_REL.
  - RIGHT: `right`=1 → WAIT_REL.
  - DOWN: `down`=1 → WAIT_REL.
  - WAIT_REL: stay until `kp`=`kr`=`kd`=0, then → IDLE.
  - OVER: all strobes 0; held until reset. Keys are ignored.
- One action per press. A held key never repeats.
- Simultaneous keys: priority is put > right > down. The others are discarded, because WAIT_REL requires all keys released.
- `turn_control` is always issued after `put`. Whether the player actually changes is the datapath's decision, based on the value latched during CHOICE; an occupied cell therefore yields no player change.
- `game_status` going nonzero mid-sequence does not abort it. The sequence completes, and OVER is entered from the next IDLE.
- Encodings: INIT=0, IDLE=1, CHOICE=2, PUT=3, TURN=4, RIGHT=5, DOWN=6, WAIT_REL=7, OVER=8. Encodings 9–15 are unreachable and recover to INIT.

## Timing
- Reset, `resetn` low at a clock edge:
  - state=INIT.
  - All strobes 0, `busy`=0.
  - Synchronizers and debounce counters cleared; debounced levels 0.
- First cycle after release: `control_set`=1 (state INIT), `busy`=1. The following cycle: state IDLE.
- Reset asserted mid-sequence aborts it on that edge. No further strobes are issued.
- Key-to-level latency: 2 cycles without debounce; 2+DEBOUNCE_CYCLES with debounce.
- Let E be the edge at which IDLE samples the level:
  - `change_able_read` is high in cycle E+1, `put` in E+2, `turn_control` in E+3.
  - `right`/`down` is high in cycle E+1.
- Minimum spacing between two actions is the release time plus one IDLE cycle.
- Debounce counters saturate at DEBOUNCE_CYCLES and never wrap.

## Configuration
- `GAME_SEQ_DEBOUNCE_EN` defined: each key gets a counter.
  - The counter resets whenever the synchronized input differs from the accepted level.
  - The accepted level flips when the counter reaches DEBOUNCE_CYCLES.
- `GAME_SEQ_DEBOUNCE_EN` undefined: the accepted level is the synchronizer output. `DEBOUNCE_CYCLES` and `DB_W` are unused.

## Structure
- Package `game_seq_pkg` holds the state type/encodings (4-bit) and the `game_status` constants (IN_PLAY=2'b00, P0_WIN=2'b01).
- Sub-module `key_debounce` (synchronizer + counter, parameterized by DEBOUNCE_CYCLES/DB_W) is instantiated three times. Its counter logic is compiled only under the macro.

## Test plan
- Reset release → `control_set` high exactly cycle 1, state=1 at cycle 2, no other strobe.
- `key_put` held 10 cycles (no debounce) → `change_able_read`, `put`, `turn_control` in three consecutive cycles once each; return to IDLE only after release.
- `key_right` and `key_put` asserted same cycle → put sequence only, zero `right` strobes; `key_right` held alone afterward → still no `right` until all keys released and re-pressed.
- `game_status`=01 forced while in PUT → TURN strobe still issued, then state 8. Further keys produce no strobes; `resetn` low for 1 cycle → INIT and `control_set` again.
- Debounce enabled, DEBOUNCE_CYCLES=8: `key_down` glitch high 5 cycles → no `down`; held 12 cycles → one `down` at edge 2+8+1 after assertion.
- `resetn` low in CHOICE → next cycle all strobes 0, state 0, no `put` issued.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// game_seq_pkg: shared types and constants for the game sequencer slice.
//   state_t      - 4-bit FSM state encoding (also exported on the debug port)
//   IN_PLAY      - game_status value while no winner has been found
//   P0_WIN       - game_status value when player 0 has won (1x = player 1)
//   game_over()  - true when the board check reports any winner
//   is_busy()    - true in every state except IDLE and OVER
package game_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_IDLE     = 4'd1,
        ST_CHOICE   = 4'd2,
        ST_PUT      = 4'd3,
        ST_TURN     = 4'd4,
        ST_RIGHT    = 4'd5,
        ST_DOWN     = 4'd6,
        ST_WAIT_REL = 4'd7,
        ST_OVER     = 4'd8
    } state_t;

    localparam logic [1:0] IN_PLAY = 2'b00;
    localparam logic [1:0] P0_WIN  = 2'b01;

    function automatic logic game_over(input logic [1:0] status);
        return (status == P0_WIN) || status[1];
    endfunction

    function automatic logic is_busy(input state_t st);
        return (st != ST_IDLE) && (st != ST_OVER);
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: key inputs, board status and datapath control strobes.
//   key_put/key_right/key_down - raw push-buttons, active-high, asynchronous
//   game_status                - board check result (00 in play)
//   control_set/right/down/change_able_read/put/turn_control - 1-cycle strobes
//   busy, state                - activity flag and state encoding for LEDs
// modport master: the sequencer; modport slave: board I/O + datapath side.
interface game_sequencer_if;
    logic       key_put;
    logic       key_right;
    logic       key_down;
    logic [1:0] game_status;
    logic       control_set;
    logic       right;
    logic       down;
    logic       change_able_read;
    logic       put;
    logic       turn_control;
    logic       busy;
    logic [3:0] state;

    modport master (
        input  key_put, key_right, key_down, game_status,
        output control_set, right, down, change_able_read, put, turn_control,
               busy, state
    );

    modport slave (
        output key_put, key_right, key_down, game_status,
        input  control_set, right, down, change_able_read, put, turn_control,
               busy, state
    );
endinterface

// File: rtl/game_sequencer_key_debounce.sv
// key_debounce: 2-flop synchronizer plus optional debounce counter for one key.
//   clock, resetn - system clock, synchronous active-low reset
//   key_in        - raw asynchronous key level
//   level         - clean key level
// With GAME_SEQ_DEBOUNCE_EN defined the level only flips after the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; otherwise
// level is the synchronizer output and the parameters only feed the range check.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic clock,
    input  logic resetn,
    input  logic key_in,
    output logic level
);

    if (DB_W < 1 || DB_W > 30 || DEBOUNCE_CYCLES < 1 ||
        DEBOUNCE_CYCLES >= (1 << DB_W)) begin : g_bad_cfg
        $error("key_debounce: DB_W too narrow for DEBOUNCE_CYCLES");
    end

    logic sync1;
    logic sync2;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

`ifdef GAME_SEQ_DEBOUNCE_EN
    localparam logic [DB_W-1:0] LIMIT = DB_W'(DEBOUNCE_CYCLES);

    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_inc;
    logic            level_q;

    // Saturating increment; the flip happens on the edge the count would reach LIMIT.
    assign cnt_inc = (cnt == LIMIT) ? cnt : cnt + DB_W'(1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (sync2 == level_q) begin
            cnt <= '0;
        end else if (cnt_inc == LIMIT) begin
            level_q <= sync2;
            cnt     <= '0;
        end else begin
            cnt <= cnt_inc;
        end
    end

    assign level = level_q;
`else
    assign level = sync2;
`endif

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: turns key presses into ordered single-cycle datapath strobes
// and freezes play once the board check reports a winner.
//   clock, resetn - system clock, synchronous active-low reset
//   bus           - game_sequencer_if.master (keys, game_status, strobes,
//                   busy, state)
// Optional macro GAME_SEQ_DEBOUNCE_EN enables the per-key debounce counters.
module game_sequencer
    import game_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic             clock,
    input  logic             resetn,
    game_sequencer_if.master bus
);

    logic kp, kr, kd;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_put (
        .clock(clock), .resetn(resetn), .key_in(bus.key_put), .level(kp)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_right (
        .clock(clock), .resetn(resetn), .key_in(bus.key_right), .level(kr)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_down (
        .clock(clock), .resetn(resetn), .key_in(bus.key_down), .level(kd)
    );

    state_t state_q, state_d;
    logic   cs_q, right_q, down_q, car_q, put_q, turn_q, busy_q;

    // Outputs are registered from the next state so each strobe lines up with
    // the state that owns it. INIT waits for its own registered control_set,
    // which gives one INIT cycle with control_set high after reset release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:     if (cs_q) state_d = ST_IDLE;
            ST_IDLE: begin
                if (game_over(bus.game_status)) state_d = ST_OVER;
                else if (kp)                    state_d = ST_CHOICE;
                else if (kr)                    state_d = ST_RIGHT;
                else if (kd)                    state_d = ST_DOWN;
            end
            ST_CHOICE:   state_d = ST_PUT;
            ST_PUT:      state_d = ST_TURN;
            ST_TURN,
            ST_RIGHT,
            ST_DOWN:     state_d = ST_WAIT_REL;
            ST_WAIT_REL: if (!(kp || kr || kd)) state_d = ST_IDLE;
            ST_OVER:     state_d = ST_OVER;
            default:     state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_INIT;
            cs_q    <= 1'b0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
            car_q   <= 1'b0;
            put_q   <= 1'b0;
            turn_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= (state_d == ST_INIT);
            right_q <= (state_d == ST_RIGHT);
            down_q  <= (state_d == ST_DOWN);
            car_q   <= (state_d == ST_CHOICE);
            put_q   <= (state_d == ST_PUT);
            turn_q  <= (state_d == ST_TURN);
            busy_q  <= is_busy(state_d);
        end
    end

    assign bus.control_set      = cs_q;
    assign bus.right            = right_q;
    assign bus.down             = down_q;
    assign bus.change_able_read = car_q;
    assign bus.put              = put_q;
    assign bus.turn_control     = turn_q;
    assign bus.busy             = busy_q;
    assign bus.state            = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenarios plus randomized key/status/reset traffic,
// every cycle compared against an action-level reference model.
module tb_game_sequencer;

    localparam int DEB = 8;
    localparam int DBW = 4;
`ifdef GAME_SEQ_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 2;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    game_sequencer_if bus();

    game_sequencer #(.DEBOUNCE_CYCLES(DEB), .DB_W(DBW)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    string       cur_tag = "reset";

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Expected output word: {control_set,right,down,change_able_read,put,turn_control,busy,state[3:0]}
    localparam logic [10:0] V_RESET  = 11'b000000_0_0000;
    localparam logic [10:0] V_START  = 11'b100000_1_0000;
    localparam logic [10:0] V_IDLE   = 11'b000000_0_0001;
    localparam logic [10:0] V_CHOICE = 11'b000100_1_0010;
    localparam logic [10:0] V_PUT    = 11'b000010_1_0011;
    localparam logic [10:0] V_TURN   = 11'b000001_1_0100;
    localparam logic [10:0] V_RIGHT  = 11'b010000_1_0101;
    localparam logic [10:0] V_DOWN   = 11'b001000_1_0110;
    localparam logic [10:0] V_REL    = 11'b000000_1_0111;
    localparam logic [10:0] V_OVER   = 11'b000000_0_1000;

    typedef enum {M_START, M_IDLE, M_RELEASE, M_OVER} mphase_t;

    mphase_t     phase = M_START;
    logic [10:0] exp_q[$];        // outputs owed by an action already started
    logic [2:0]  key_dly[$] = '{3'b000, 3'b000}; // raw keys, synchronizer delay
    logic [2:0]  s2_hist[$];      // recent synchronized samples (debounce model)
    logic [2:0]  acc = 3'b000;    // accepted key levels {put,right,down}
    logic [10:0] exp_now;

    // Computes the output expected after the coming edge from the inputs
    // presented to it.
    task automatic model_step();
        logic [2:0] keys_now;
        logic [2:0] s2;
        logic [2:0] lvl;
        keys_now = {bus.key_put, bus.key_right, bus.key_down};
        if (!resetn) begin
            key_dly = '{3'b000, 3'b000};
            s2_hist.delete();
            acc = 3'b000;
            exp_q.delete();
            phase = M_START;
            exp_now = V_RESET;
            return;
        end
        s2 = key_dly.pop_front();
        key_dly.push_back(keys_now);
`ifdef GAME_SEQ_DEBOUNCE_EN
        begin
            logic [2:0] acc_n;
            lvl = acc;
            acc_n = acc;
            s2_hist.push_back(s2);
            if (s2_hist.size() > DEB) void'(s2_hist.pop_front());
            for (int b = 0; b < 3; b++) begin
                bit all_diff;
                all_diff = (s2_hist.size() == DEB);
                foreach (s2_hist[i]) if (s2_hist[i][b] == acc[b]) all_diff = 0;
                if (all_diff) acc_n[b] = ~acc[b];
            end
            acc = acc_n;
        end
`else
        lvl = s2;
`endif
        if (exp_q.size() != 0) begin
            exp_now = exp_q.pop_front();
            return;
        end
        case (phase)
            M_START: begin
                exp_now = V_START;
                exp_q.push_back(V_IDLE);
                phase = M_IDLE;
            end
            M_IDLE: begin
                if (bus.game_status != 2'b00) begin
                    exp_now = V_OVER;
                    phase = M_OVER;
                end else if (lvl[2]) begin
                    exp_now = V_CHOICE;
                    exp_q.push_back(V_PUT);
                    exp_q.push_back(V_TURN);
                    exp_q.push_back(V_REL);
                    phase = M_RELEASE;
                end else if (lvl[1]) begin
                    exp_now = V_RIGHT;
                    exp_q.push_back(V_REL);
                    phase = M_RELEASE;
                end else if (lvl[0]) begin
                    exp_now = V_DOWN;
                    exp_q.push_back(V_REL);
                    phase = M_RELEASE;
                end else begin
                    exp_now = V_IDLE;
                end
            end
            M_RELEASE: begin
                if (lvl == 3'b000) begin
                    exp_now = V_IDLE;
                    phase = M_IDLE;
                end else begin
                    exp_now = V_REL;
                end
            end
            default: exp_now = V_OVER;
        endcase
    endtask

    task automatic tick();
        logic [10:0] obs;
        model_step();
        @(posedge clock);
        #1;
        obs = {bus.control_set, bus.right, bus.down, bus.change_able_read,
               bus.put, bus.turn_control, bus.busy, bus.state};
        check_eq(cur_tag, 32'(obs), 32'(exp_now));
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_keys(input logic p, input logic r, input logic d);
        bus.key_put   = p;
        bus.key_right = r;
        bus.key_down  = d;
    endtask

    initial begin
        set_keys(0, 0, 0);
        bus.game_status = 2'b00;
        resetn = 1'b0;

        cur_tag = "reset";
        run(3);
        resetn = 1'b1;
        run(4);

        cur_tag = "put_held";
        set_keys(1, 0, 0);
        run(LAT + 10);
        set_keys(0, 0, 0);
        run(LAT + 3);

        cur_tag = "put_right_same";
        set_keys(1, 1, 0);
        run(LAT + 6);
        set_keys(0, 1, 0);
        run(LAT + 8);
        set_keys(0, 0, 0);
        run(LAT + 3);
        set_keys(0, 1, 0);
        run(LAT + 4);
        set_keys(0, 0, 0);
        run(LAT + 3);

        cur_tag = "down";
        set_keys(0, 0, 1);
        run(LAT + 4);
        set_keys(0, 0, 0);
        run(LAT + 3);

        cur_tag = "glitch_down";
        set_keys(0, 0, 1);
        run(5);
        set_keys(0, 0, 0);
        run(LAT + 4);

        cur_tag = "win_mid_put";
        set_keys(1, 0, 0);
        run(LAT + 2);
        bus.game_status = 2'b01;
        run(3);
        set_keys(0, 0, 0);
        run(LAT + 4);
        set_keys(0, 1, 0);
        run(LAT + 4);
        set_keys(1, 0, 1);
        run(LAT + 4);
        set_keys(0, 0, 0);
        bus.game_status = 2'b00;
        resetn = 1'b0;
        run(1);
        resetn = 1'b1;
        run(4);

        cur_tag = "reset_in_choice";
        set_keys(1, 0, 0);
        run(LAT + 1);
        resetn = 1'b0;
        run(1);
        set_keys(0, 0, 0);
        resetn = 1'b1;
        run(LAT + 5);

        cur_tag = "random";
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0)
                set_keys(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0)
                bus.game_status = 2'($urandom_range(1, 3));
            resetn = 1'b1;
            if (bus.game_status != 2'b00 && $urandom_range(0, 39) == 0) begin
                resetn = 1'b0;
                bus.game_status = 2'b00;
            end else if ($urandom_range(0, 399) == 0) begin
                resetn = 1'b0;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
